mipi_csi_rx_frame_controller_8b2lane: RTL and testbench
=======================================================

Name: mipi_csi_rx_frame_controller_8b2lane

Overview:
Frame-level sequencer for the 2-lane, 8-bit CSI-2 receive path. It watches the lane-aligned byte stream for short packets (Frame Start, Frame End, Line Start, Line End) and runs a frame/line state machine. It gates the packet decoder's data_valid so that only in-frame traffic reaches the decoder. It also checks the decoder's output for per-line byte count and lines per frame, and produces frame_valid/line_valid, counters and sticky error flags for the parallel bridge and the USB streaming logic.

Parameters:
LINE_CNT_W, 16, width of the line counter and of expected_lines_i.
FRAME_CNT_W, 16, width of the frame counter (wraps).
TIMEOUT_CYCLES, 24'd1000000, watchdog limit in clk_i cycles (used only with the optional feature).

Ports:
clk_i  in  1  MIPI byte clock.
reset_n_i  in  1  asynchronous, active-low reset.
enable_i  in  1  arm controller; sampled at frame boundaries only.
data_valid_i  in  1  lane-aligner valid.
data_i  in  16  lane-aligned bytes; lane0 in [7:0], lane1 in [15:8].
decoder_valid_i  in  1  packet decoder output_valid.
decoder_length_i  in  16  packet decoder packet_length.
expected_lines_i  in  LINE_CNT_W  lines per frame; 0 disables the check.
expected_bytes_i  in  16  bytes per line; 0 disables the check.
decoder_data_valid_o  out  1  gated data_valid to the decoder.
frame_valid_o  out  1  high from FS to FE.
line_valid_o  out  1  mirrors decoder_valid_i while in frame.
line_count_o  out  LINE_CNT_W  lines completed in the current frame.
frame_count_o  out  FRAME_CNT_W  frames completed.
err_o  out  4  sticky: [0] line length, [1] line count, [2] FS while in frame, [3] timeout.
err_clr_i  in  1  clears err_o.

Behaviour:
- Reset: all outputs 0 and state IDLE. Reset acts asynchronously; removal is synchronous.
- Short-packet detect: a cycle where data_valid_i=1 and data_i[7:0]=8'hB8, followed by the next valid cycle where data_i[7:0] is the DataID (0x00 FS, 0x01 FE, 0x02 LS, 0x03 LE).
  - Detection is registered: the event pulse appears 2 cycles after the sync byte.
  - An invalid cycle between the sync and DataID cycles aborts detection.
- States:
  - IDLE: wait for enable_i=1, then go to WAIT_FS.
  - WAIT_FS: on FS, go to FRAME. frame_valid_o rises on the FS event cycle, line_count_o is cleared and errors are not cleared.
  - FRAME: on FE, go to WAIT_FS if enable_i=1, else IDLE. frame_valid_o falls the next cycle and frame_count_o increments (wrap).
  - ERROR: none; errors are flags only and never stall the FSM.
- Gating: decoder_data_valid_o = data_valid_i registered, AND (state==FRAME).
  - 1 cycle latency.
  - data_i must be delayed by the same 1 cycle by the integrator; the controller provides no data port.
- Line tracking in FRAME:
  - Each decoder_valid_i cycle adds 2 to a 16-bit byte counter (saturating at 16'hFFFF).
  - On the decoder_valid_i falling edge: line_count_o increments (saturates at all-ones). If expected_bytes_i≠0 and byte count ≠ expected_bytes_i, set err_o[0]. Byte counter then clears.
- On FE: if expected_lines_i≠0 and line_count_o (including a line ending in the same cycle) ≠ expected_lines_i, set err_o[1].
- FS received in FRAME: set err_o[2], restart the frame (line_count_o cleared), frame_count_o unchanged.
- FE in WAIT_FS and LS/LE in any state: ignored. LS/LE are informational only.
- err_clr_i and a new error in the same cycle: the new error wins (bit ends up set).
- enable_i deasserted mid-frame: the frame completes normally and the FSM then goes to IDLE.
- data_valid_i low: FSM holds state and no counter changes. A decoder_valid_i fall is still processed.

Optional Feature:
MIPI_CSI_FRAME_TIMEOUT_EN:
- Defined: a watchdog counts cycles in FRAME and resets on every data_valid_i=1 cycle. At TIMEOUT_CYCLES it sets err_o[3], forces frame_valid_o low and returns to WAIT_FS; frame_count_o does not increment.
- Undefined: no counter is built, err_o[3] is tied 0 and FRAME exits only on FE or FS.

Decomposition:
- Shared package mipi_csi_pkg:
  - SYNC_BYTE=8'hB8.
  - DataID constants FS/FE/LS/LE (8'h00–8'h03) and RAW10/12/14 (8'h2B–8'h2D).
  - FSM state typedef (IDLE, WAIT_FS, FRAME).
  - err bit index constants.
- One sub-module: mipi_csi_short_packet_detect. It takes data_valid_i/data_i and emits registered fs/fe/ls/le pulses.

Test Plan:
- Reset with reset_n_i=0 mid-frame -> all outputs 0 immediately; after release with enable_i=1, state WAIT_FS.
- FS, then 4 lines of 640 bytes each (320 decoder_valid cycles), then FE, with expected_lines_i=4 and expected_bytes_i=640 -> frame_valid_o spans FS..FE+1, line_count_o=4, frame_count_o=1, err_o=0.
- Same stream with one line of 638 bytes -> err_o[0]=1, err_o[1]=0. Then err_clr_i pulse -> err_o=0.
- FS, 3 lines, FS, 4 lines, FE with expected_lines_i=4 -> err_o[2]=1, line_count_o=4, frame_count_o=1, err_o[1]=0.
- Sync byte B8, then a data_valid_i gap, then DataID 0x00 -> no FS detected and decoder_data_valid_o stays 0.
- With MIPI_CSI_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=100: FS, then data_valid_i=0 for 100 cycles -> err_o[3]=1, frame_valid_o=0, frame_count_o unchanged.

Source files
------------

// File: rtl/mipi_csi_pkg.sv
// ============================================================================
// Module   : mipi_csi_pkg
// Brief    : Shared CSI-2 constants, frame FSM state type and error bit map.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mipi_csi_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [7:0] DT_FS    = 8'h00;
  localparam logic [7:0] DT_FE    = 8'h01;
  localparam logic [7:0] DT_LS    = 8'h02;
  localparam logic [7:0] DT_LE    = 8'h03;
  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;
  localparam logic [7:0] DT_RAW14 = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_FRAME   = 2'd2
  } frame_state_t;

  localparam int ERR_LINE_LEN    = 0;
  localparam int ERR_LINE_CNT    = 1;
  localparam int ERR_FS_IN_FRAME = 2;
  localparam int ERR_TIMEOUT     = 3;

  // Two bytes per beat on a 2-lane link; pins at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add2(input logic [15:0] value);
    sat_add2 = (value >= 16'hFFFE) ? 16'hFFFF : value + 16'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mipi_csi_short_packet_detect.sv
// ============================================================================
// Module   : mipi_csi_short_packet_detect
// Brief    : Spots sync byte + DataID on lane 0; emits registered FS/FE/LS/LE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mipi_csi_short_packet_detect
  import mipi_csi_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_byte_i,
  output logic       fs_o,
  output logic       fe_o,
  output logic       ls_o,
  output logic       le_o
);

  logic r_sync_seen;
  logic w_id_cycle;

  // The DataID must arrive on the very next clock; a gap drops r_sync_seen.
  assign w_id_cycle = r_sync_seen && data_valid_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sync_seen <= 1'b0;
      fs_o        <= 1'b0;
      fe_o        <= 1'b0;
      ls_o        <= 1'b0;
      le_o        <= 1'b0;
    end else begin
      r_sync_seen <= data_valid_i && (data_byte_i == SYNC_BYTE);
      fs_o        <= w_id_cycle && (data_byte_i == DT_FS);
      fe_o        <= w_id_cycle && (data_byte_i == DT_FE);
      ls_o        <= w_id_cycle && (data_byte_i == DT_LS);
      le_o        <= w_id_cycle && (data_byte_i == DT_LE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mipi_csi_rx_frame_controller_8b2lane.sv
// ============================================================================
// Module   : mipi_csi_rx_frame_controller_8b2lane
// Brief    : Frame/line sequencer, decoder valid gating and line/frame checks.
//            Optional watchdog: define MIPI_CSI_FRAME_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mipi_csi_rx_frame_controller_8b2lane
  import mipi_csi_pkg::*;
#(
  parameter int          LINE_CNT_W     = 16,
  parameter int          FRAME_CNT_W    = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic                   data_valid_i,
  input  logic [15:0]            data_i,
  input  logic                   decoder_valid_i,
  input  logic [15:0]            decoder_length_i,
  input  logic [LINE_CNT_W-1:0]  expected_lines_i,
  input  logic [15:0]            expected_bytes_i,
  output logic                   decoder_data_valid_o,
  output logic                   frame_valid_o,
  output logic                   line_valid_o,
  output logic [LINE_CNT_W-1:0]  line_count_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o,
  output logic [3:0]             err_o,
  input  logic                   err_clr_i
);

  frame_state_t           r_state, w_state_next;
  logic                   w_fs, w_fe, w_ls, w_le;
  logic                   r_dv_d, r_dec_d;
  logic [15:0]            r_byte_cnt;
  logic [LINE_CNT_W-1:0]  r_line_cnt, w_line_inc, w_lines_eff;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [3:0]             r_err, w_err_set;
  logic                   w_in_frame, w_line_end, w_timeout;
  logic                   w_frame_start, w_frame_end, w_fs_err, w_timeout_exit;
  logic                   w_unused;

  mipi_csi_short_packet_detect u_detect (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .data_valid_i (data_valid_i),
    .data_byte_i  (data_i[7:0]),
    .fs_o         (w_fs),
    .fe_o         (w_fe),
    .ls_o         (w_ls),
    .le_o         (w_le)
  );

  // LS/LE are informational and lane 1 carries no short-packet header.
  assign w_unused = ^{w_ls, w_le, data_i[15:8], decoder_length_i};

  assign w_in_frame  = (r_state == ST_FRAME);
  assign w_line_end  = w_in_frame && r_dec_d && !decoder_valid_i;
  assign w_line_inc  = (&r_line_cnt) ? r_line_cnt : r_line_cnt + 1'b1;
  assign w_lines_eff = w_line_end ? w_line_inc : r_line_cnt;

`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
  logic [23:0] r_wd_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd_cnt <= 24'd0;
    end else if (!w_in_frame || data_valid_i) begin
      r_wd_cnt <= 24'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 24'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
  assign w_timeout = w_in_frame && !data_valid_i && (r_wd_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_frame_start  = 1'b0;
    w_frame_end    = 1'b0;
    w_fs_err       = 1'b0;
    w_timeout_exit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) w_state_next = ST_WAIT_FS;
      end
      ST_WAIT_FS: begin
        if (w_fs) begin
          w_state_next  = ST_FRAME;
          w_frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (w_fs) begin
          w_frame_start = 1'b1;
          w_fs_err      = 1'b1;
        end else if (w_fe) begin
          w_frame_end  = 1'b1;
          w_state_next = enable_i ? ST_WAIT_FS : ST_IDLE;
        end else if (w_timeout) begin
          w_timeout_exit = 1'b1;
          w_state_next   = ST_WAIT_FS;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_dv_d      <= 1'b0;
      r_dec_d     <= 1'b0;
      r_byte_cnt  <= 16'd0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_dv_d  <= data_valid_i;
      r_dec_d <= decoder_valid_i;
      if (w_frame_start) begin
        r_line_cnt <= '0;
        r_byte_cnt <= 16'd0;
      end else if (w_line_end) begin
        r_line_cnt <= w_line_inc;
        r_byte_cnt <= 16'd0;
      end else if (w_in_frame && decoder_valid_i) begin
        r_byte_cnt <= sat_add2(r_byte_cnt);
      end else if (!w_in_frame) begin
        r_byte_cnt <= 16'd0;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_comb begin
    w_err_set                  = 4'd0;
    w_err_set[ERR_LINE_LEN]    = w_line_end && (expected_bytes_i != 16'd0) &&
                                 (r_byte_cnt != expected_bytes_i);
    w_err_set[ERR_LINE_CNT]    = w_frame_end && (expected_lines_i != '0) &&
                                 (w_lines_eff != expected_lines_i);
    w_err_set[ERR_FS_IN_FRAME] = w_fs_err;
    w_err_set[ERR_TIMEOUT]     = w_timeout_exit;
  end

  // A fresh error in the clear cycle survives the clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err <= 4'd0;
    end else begin
      r_err <= (r_err & ~{4{err_clr_i}}) | w_err_set;
    end
  end

  assign decoder_data_valid_o = r_dv_d && w_in_frame;
  assign frame_valid_o        = w_in_frame || ((r_state == ST_WAIT_FS) && w_fs);
  assign line_valid_o         = decoder_valid_i && w_in_frame;
  assign line_count_o         = r_line_cnt;
  assign frame_count_o        = r_frame_cnt;
  assign err_o                = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mipi_csi_rx_frame_controller_8b2lane.sv
// ============================================================================
// Module   : tb_mipi_csi_rx_frame_controller_8b2lane
// Brief    : Directed self-checking bench for the CSI-2 frame controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mipi_csi_rx_frame_controller_8b2lane;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        data_valid_i;
  logic [15:0] data_i;
  logic        decoder_valid_i;
  logic [15:0] decoder_length_i;
  logic [15:0] expected_lines_i;
  logic [15:0] expected_bytes_i;
  logic        decoder_data_valid_o;
  logic        frame_valid_o;
  logic        line_valid_o;
  logic [15:0] line_count_o;
  logic [15:0] frame_count_o;
  logic [3:0]  err_o;
  logic        err_clr_i;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  mipi_csi_rx_frame_controller_8b2lane #(
    .LINE_CNT_W     (16),
    .FRAME_CNT_W    (16),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .enable_i             (enable_i),
    .data_valid_i         (data_valid_i),
    .data_i               (data_i),
    .decoder_valid_i      (decoder_valid_i),
    .decoder_length_i     (decoder_length_i),
    .expected_lines_i     (expected_lines_i),
    .expected_bytes_i     (expected_bytes_i),
    .decoder_data_valid_o (decoder_data_valid_o),
    .frame_valid_o        (frame_valid_o),
    .line_valid_o         (line_valid_o),
    .line_count_o         (line_count_o),
    .frame_count_o        (frame_count_o),
    .err_o                (err_o),
    .err_clr_i            (err_clr_i)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic idle(input int n);
    data_valid_i    = 1'b0;
    data_i          = 16'h0000;
    decoder_valid_i = 1'b0;
    step(n);
  endtask

  // Leaves the bench in the cycle where the detector pulse is visible.
  task automatic short_pkt(input logic [7:0] id);
    decoder_valid_i = 1'b0;
    data_valid_i    = 1'b1;
    data_i          = {8'h00, 8'hB8};
    step(1);
    data_i          = {8'h00, id};
    step(1);
    data_valid_i    = 1'b0;
    data_i          = 16'h0000;
  endtask

  task automatic send_line(input int nbytes);
    data_valid_i    = 1'b1;
    data_i          = 16'h1234;
    decoder_valid_i = 1'b1;
    step(nbytes / 2);
    data_valid_i    = 1'b0;
    data_i          = 16'h0000;
    decoder_valid_i = 1'b0;
    step(1);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
  endtask

  initial begin
    reset_n_i        = 1'b0;
    enable_i         = 1'b0;
    data_valid_i     = 1'b0;
    data_i           = 16'h0000;
    decoder_valid_i  = 1'b0;
    decoder_length_i = 16'd640;
    expected_lines_i = 16'd4;
    expected_bytes_i = 16'd640;
    err_clr_i        = 1'b0;
    step(3);
    check_value("rst_fv", frame_valid_o, 0);
    check_value("rst_fc", frame_count_o, 0);
    check_value("rst_err", err_o, 0);

    // Reset asserted mid-frame clears everything at once.
    reset_n_i = 1'b1;
    enable_i  = 1'b1;
    idle(2);
    short_pkt(8'h00);
    check_value("fs_rise", frame_valid_o, 1);
    idle(1);
    send_line(8);
    check_value("pre_rst_lc", line_count_o, 1);
    check_value("pre_rst_err", err_o, 4'b0001);
    data_valid_i    = 1'b1;
    decoder_valid_i = 1'b1;
    step(1);
    check_value("pre_rst_lv", line_valid_o, 1);
    check_value("pre_rst_ddv", decoder_data_valid_o, 1);
    reset_n_i = 1'b0;
    #1;
    check_value("async_rst_fv", frame_valid_o, 0);
    check_value("async_rst_lv", line_valid_o, 0);
    check_value("async_rst_ddv", decoder_data_valid_o, 0);
    check_value("async_rst_lc", line_count_o, 0);
    check_value("async_rst_err", err_o, 0);
    idle(2);
    reset_n_i = 1'b1;
    idle(2);

    // Clean frame: 4 lines x 640 bytes.
    short_pkt(8'h00);
    check_value("a_fs_fv", frame_valid_o, 1);
    idle(1);
    data_valid_i    = 1'b1;
    data_i          = 16'h1234;
    decoder_valid_i = 1'b1;
    step(1);
    check_value("a_ddv", decoder_data_valid_o, 1);
    check_value("a_lv", line_valid_o, 1);
    step(319);
    idle(1);
    for (int i = 0; i < 3; i++) send_line(640);
    check_value("a_lc", line_count_o, 4);
    short_pkt(8'h01);
    check_value("a_fe_fv", frame_valid_o, 1);
    idle(1);
    check_value("a_post_fv", frame_valid_o, 0);
    check_value("a_fc", frame_count_o, 1);
    check_value("a_lc_hold", line_count_o, 4);
    check_value("a_err", err_o, 0);

    // Short line sets only the line-length error.
    short_pkt(8'h00);
    idle(1);
    check_value("b_lc_clr", line_count_o, 0);
    send_line(640);
    send_line(638);
    send_line(640);
    send_line(640);
    short_pkt(8'h01);
    idle(1);
    check_value("b_err", err_o, 4'b0001);
    check_value("b_fc", frame_count_o, 2);
    clear_errors();
    check_value("b_err_clr", err_o, 0);

    // FS inside a frame restarts it.
    expected_bytes_i = 16'd0;
    short_pkt(8'h00);
    idle(1);
    for (int i = 0; i < 3; i++) send_line(8);
    check_value("c_lc3", line_count_o, 3);
    short_pkt(8'h00);
    check_value("c_fs2_fv", frame_valid_o, 1);
    idle(1);
    check_value("c_lc_restart", line_count_o, 0);
    check_value("c_err_fs", err_o, 4'b0100);
    for (int i = 0; i < 4; i++) send_line(8);
    short_pkt(8'h01);
    idle(1);
    check_value("c_err", err_o, 4'b0100);
    check_value("c_lc", line_count_o, 4);
    check_value("c_fc", frame_count_o, 3);
    clear_errors();

    // Too few lines.
    short_pkt(8'h00);
    idle(1);
    for (int i = 0; i < 3; i++) send_line(8);
    short_pkt(8'h01);
    idle(1);
    check_value("d_err", err_o, 4'b0010);
    check_value("d_fc", frame_count_o, 4);
    clear_errors();

    // Gap between sync and DataID aborts detection.
    data_valid_i = 1'b1;
    data_i       = {8'h00, 8'hB8};
    step(1);
    data_valid_i = 1'b0;
    step(1);
    data_valid_i = 1'b1;
    data_i       = 16'h0000;
    step(1);
    data_valid_i = 1'b0;
    check_value("e_fv0", frame_valid_o, 0);
    step(1);
    check_value("e_fv1", frame_valid_o, 0);
    data_valid_i    = 1'b1;
    decoder_valid_i = 1'b1;
    step(1);
    check_value("e_ddv", decoder_data_valid_o, 0);
    check_value("e_lv", line_valid_o, 0);
    idle(1);
    check_value("e_lc", line_count_o, 3);
    short_pkt(8'h01);
    idle(1);
    check_value("e_fe_ignored", frame_count_o, 4);

    // Enable dropped mid-frame: frame completes, then IDLE ignores FS.
    expected_lines_i = 16'd0;
    short_pkt(8'h00);
    idle(1);
    enable_i = 1'b0;
    send_line(8);
    short_pkt(8'h01);
    idle(1);
    check_value("f_fc", frame_count_o, 5);
    check_value("f_fv", frame_valid_o, 0);
    short_pkt(8'h00);
    check_value("f_idle_fs", frame_valid_o, 0);
    idle(1);
    check_value("f_idle_fv", frame_valid_o, 0);
    enable_i = 1'b1;
    idle(1);
    short_pkt(8'h00);
    check_value("f_rearm_fv", frame_valid_o, 1);
    idle(1);
    short_pkt(8'h01);
    idle(1);
    check_value("f_fc2", frame_count_o, 6);
    check_value("f_err", err_o, 0);

`ifdef MIPI_CSI_FRAME_TIMEOUT_EN
    short_pkt(8'h00);
    idle(1);
    idle(105);
    check_value("t_err", err_o, 4'b1000);
    check_value("t_fv", frame_valid_o, 0);
    check_value("t_fc", frame_count_o, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
